// File: rtl/hidden_layer_pkg.sv
// hidden_layer_pkg: shared constants and types for the hidden-layer feeder path.
package hidden_layer_pkg;
   localparam int LANES = 32;
   localparam int LANE_W = 10;
   localparam int NUM_TERMS = 480;
   typedef enum logic [2:0] {IDLE, CLR, FILL, ISSUE, DONE} feeder_state_t;
   typedef logic [LANES*LANE_W-1:0] lane_vec_t;
endpackage

// File: rtl/lane_packer.sv
// lane_packer: serial-to-parallel pack register with a wrapping lane index.
module lane_packer #(
   parameter int LANES = hidden_layer_pkg::LANES,
   parameter int LANE_W = hidden_layer_pkg::LANE_W
) (
   input  logic                    Clock,
   input  logic                    Clear,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic [LANE_W-1:0]       wr_data,
   output logic                    full,
   output logic [LANES*LANE_W-1:0] vec_next
);
   localparam int IW = $clog2(LANES);
   logic [IW-1:0] lane_cnt;
   logic [LANES*LANE_W-1:0] vec;
   // vec_next includes the lane being written now, so the last sample is visible at the issue edge
   always_comb begin
      vec_next = vec;
      vec_next[lane_cnt*LANE_W +: LANE_W] = wr_data;
   end
   assign full = lane_cnt == IW'(LANES-1);
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         lane_cnt <= '0;
         vec <= '0;
      end else if (clr) begin
         lane_cnt <= '0;
      end else if (wr_en) begin
         vec <= vec_next;
         lane_cnt <= full ? '0 : lane_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/hidden_layer_feeder.sv
// hidden_layer_feeder: packs serial samples into lane vectors and issues one
// weighted accumulate beat per vector, NUM_TERMS beats per neuron pass.
module hidden_layer_feeder import hidden_layer_pkg::*; #(
   parameter int LANES = hidden_layer_pkg::LANES,
   parameter int LANE_W = hidden_layer_pkg::LANE_W,
   parameter int NUM_TERMS = hidden_layer_pkg::NUM_TERMS,
   parameter int WADDR_W = 9
) (
   input  logic                    Clock,
   input  logic                    Clear,
   input  logic                    start,
   input  logic                    s_valid,
   input  logic [LANE_W-1:0]       s_data,
   output logic                    s_ready,
   output logic [WADDR_W-1:0]      w_addr,
   input  logic [LANE_W-1:0]       w_data,
   output logic                    acc_clr,
   output logic                    acc_val,
   output logic [LANES*LANE_W-1:0] acc_vec,
   output logic [LANE_W-1:0]       acc_weight,
   output logic                    busy,
   output logic                    done
);
   feeder_state_t state;
   logic [WADDR_W-1:0] term_cnt;
   logic full, xfer;
   logic [LANES*LANE_W-1:0] vec_next;
   assign xfer = s_valid && s_ready;
   assign w_addr = term_cnt;
   lane_packer #(.LANES(LANES), .LANE_W(LANE_W)) u_packer (
      .Clock(Clock),
      .Clear(Clear),
      .clr(state == CLR),
      .wr_en(xfer),
      .wr_data(s_data),
      .full(full),
      .vec_next(vec_next)
   );
   // w_addr has been stable for the whole FILL, so w_data is captured straight into acc_weight
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state <= IDLE;
         term_cnt <= '0;
         s_ready <= 1'b0;
         acc_clr <= 1'b0;
         acc_val <= 1'b0;
         acc_vec <= '0;
         acc_weight <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         acc_clr <= 1'b0;
         acc_val <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= CLR;
               acc_clr <= 1'b1;
               busy <= 1'b1;
            end
            CLR: begin
               term_cnt <= '0;
               s_ready <= 1'b1;
               state <= FILL;
            end
            FILL: if (xfer && full) begin
               state <= ISSUE;
               s_ready <= 1'b0;
               acc_val <= 1'b1;
               acc_vec <= vec_next;
               acc_weight <= w_data;
            end
            ISSUE: if (term_cnt == WADDR_W'(NUM_TERMS-1)) begin
               state <= DONE;
               done <= 1'b1;
            end else begin
               term_cnt <= term_cnt + 1'b1;
               s_ready <= 1'b1;
               state <= FILL;
            end
            DONE: begin
               term_cnt <= '0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hidden_layer_feeder.sv
// tb_hidden_layer_feeder: scoreboard bench for a short-pass (NUM_TERMS=2) and a full-pass feeder.
`timescale 1ns/1ps
module tb_hidden_layer_feeder;
   import hidden_layer_pkg::*;
   typedef struct {
      lane_vec_t vec;
      logic [LANE_W-1:0] w;
      int term;
   } beat_t;
   logic Clock = 1'b0;
   logic Clear = 1'b0;
   logic start [2];
   logic s_valid [2];
   logic s_ready [2];
   logic acc_clr [2];
   logic acc_val [2];
   logic busy [2];
   logic done [2];
   logic [LANE_W-1:0] s_data [2];
   logic [LANE_W-1:0] w_data [2];
   logic [LANE_W-1:0] acc_weight [2];
   logic [8:0] w_addr [2];
   lane_vec_t acc_vec [2];
   logic [LANE_W-1:0] wmem [2][512];
   beat_t q [2][$];
   beat_t mb;
   int checks = 0, errors = 0, cyc = 0;
   int clr_n [2], val_n [2], done_n [2];
   int clr_cyc [2], val_cyc [2], prev_val_cyc [2], done_cyc [2];
   longint act_sum [2];
   longint exp_sum;

   hidden_layer_feeder #(.NUM_TERMS(2)) dut_a (
      .Clock(Clock), .Clear(Clear), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
      .s_ready(s_ready[0]), .w_addr(w_addr[0]), .w_data(w_data[0]), .acc_clr(acc_clr[0]),
      .acc_val(acc_val[0]), .acc_vec(acc_vec[0]), .acc_weight(acc_weight[0]), .busy(busy[0]), .done(done[0])
   );
   hidden_layer_feeder dut_b (
      .Clock(Clock), .Clear(Clear), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
      .s_ready(s_ready[1]), .w_addr(w_addr[1]), .w_data(w_data[1]), .acc_clr(acc_clr[1]),
      .acc_val(acc_val[1]), .acc_vec(acc_vec[1]), .acc_weight(acc_weight[1]), .busy(busy[1]), .done(done[1])
   );

   always #5 Clock = ~Clock;

   // synchronous weight memory: one cycle of read latency
   always @(posedge Clock) begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) w_data[d] <= wmem[d][w_addr[d]];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge Clock) begin
      if (Clear) for (int d = 0; d < 2; d++) begin
         if (int'(acc_clr[d]) + int'(acc_val[d]) + int'(done[d]) > 1) begin
            checks++;
            errors++;
            $display("FAIL exclusive_strobes dut%0d clr=%b val=%b done=%b", d, acc_clr[d], acc_val[d], done[d]);
         end
         if (acc_clr[d]) begin clr_n[d]++; clr_cyc[d] = cyc; end
         if (done[d]) begin done_n[d]++; done_cyc[d] = cyc; end
         if (acc_val[d]) begin
            prev_val_cyc[d] = val_cyc[d];
            val_cyc[d] = cyc;
            val_n[d]++;
            for (int l = 0; l < LANES; l++)
               act_sum[d] += longint'(acc_vec[d][l*LANE_W +: LANE_W]) * longint'($signed(acc_weight[d]));
            if (q[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat dut%0d got acc_val=1 want no beat", d);
            end else begin
               mb = q[d].pop_front();
               checks++;
               if (acc_vec[d] !== mb.vec) begin
                  errors++;
                  $display("FAIL beat_vec dut%0d term %0d got %h want %h", d, mb.term, acc_vec[d], mb.vec);
               end
               chk($sformatf("beat_weight dut%0d term %0d", d, mb.term), longint'(acc_weight[d]), longint'(mb.w));
               chk($sformatf("beat_w_addr dut%0d", d), longint'(w_addr[d]), longint'(mb.term));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic reset_counts();
      for (int d = 0; d < 2; d++) begin
         clr_n[d] = 0; val_n[d] = 0; done_n[d] = 0;
         clr_cyc[d] = 0; val_cyc[d] = 0; prev_val_cyc[d] = 0; done_cyc[d] = 0;
      end
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1'b1;
      tick(1);
      start[d] = 1'b0;
   endtask

   task automatic feed(input int d, input logic [LANE_W-1:0] v, input bit gap);
      int n = 0;
      s_valid[d] = 1'b1;
      s_data[d] = v;
      do begin
         @(negedge Clock);
         n++;
      end while (!s_ready[d] && n < 200);
      if (!s_ready[d]) chk($sformatf("feed_timeout dut%0d", d), 0, 1);
      tick(1);
      s_valid[d] = 1'b0;
      if (gap) tick(1);
   endtask

   task automatic wait_done(input int d, input int lim);
      int k = 0;
      while (done_n[d] == 0 && k < lim) begin
         @(posedge Clock);
         k++;
      end
      #1;
      chk($sformatf("done_seen dut%0d", d), done_n[d], 1);
   endtask

   task automatic push_seq(input int d, input int term, input int first);
      beat_t b;
      for (int i = 0; i < LANES; i++) b.vec[i*LANE_W +: LANE_W] = LANE_W'(first + i);
      b.w = (term != 0) ? 10'd5 : 10'h3FD;
      b.term = term;
      q[d].push_back(b);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [LANE_W-1:0] lv [LANES];
      beat_t b;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = '0; act_sum[d] = 0;
         for (int a = 0; a < 512; a++) wmem[d][a] = (d == 1) ? LANE_W'($urandom) : '0;
      end
      wmem[0][0] = 10'h3FD;
      wmem[0][1] = 10'd5;
      reset_counts();
      // reset then idle
      tick(3);
      Clear = 1'b1;
      tick(10);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("idle_s_ready dut%0d", d), s_ready[d], 0);
         chk($sformatf("idle_w_addr dut%0d", d), w_addr[d], 0);
         chk($sformatf("idle_acc_clr dut%0d", d), acc_clr[d], 0);
         chk($sformatf("idle_acc_val dut%0d", d), acc_val[d], 0);
         chk($sformatf("idle_acc_vec_nonzero dut%0d", d), acc_vec[d] != '0, 0);
         chk($sformatf("idle_acc_weight dut%0d", d), acc_weight[d], 0);
         chk($sformatf("idle_busy dut%0d", d), busy[d], 0);
         chk($sformatf("idle_done dut%0d", d), done[d], 0);
      end
      // single short pass, samples 1..64 back to back
      reset_counts();
      push_seq(0, 0, 1);
      push_seq(0, 1, 33);
      pulse_start(0);
      for (int i = 1; i <= 64; i++) feed(0, LANE_W'(i), 1'b0);
      wait_done(0, 100);
      chk("pass_clr_count", clr_n[0], 1);
      chk("pass_val_count", val_n[0], 2);
      chk("pass_clr_to_val", prev_val_cyc[0] - clr_cyc[0], 33);
      chk("pass_val_interval", val_cyc[0] - prev_val_cyc[0], 33);
      chk("pass_done_after_val", done_cyc[0] - val_cyc[0], 1);
      chk("pass_busy_after", busy[0], 0);
      chk("pass_queue_left", q[0].size(), 0);
      // valid toggling every cycle
      reset_counts();
      push_seq(0, 0, 100);
      push_seq(0, 1, 132);
      pulse_start(0);
      for (int i = 100; i < 164; i++) feed(0, LANE_W'(i), 1'b1);
      wait_done(0, 100);
      chk("gap_clr_to_val", prev_val_cyc[0] - clr_cyc[0], 64);
      chk("gap_val_interval", val_cyc[0] - prev_val_cyc[0], 64);
      chk("gap_val_count", val_n[0], 2);
      chk("gap_queue_left", q[0].size(), 0);
      // start asserted mid-FILL is ignored
      reset_counts();
      push_seq(0, 0, 200);
      push_seq(0, 1, 232);
      pulse_start(0);
      fork
         for (int i = 200; i < 264; i++) feed(0, LANE_W'(i), 1'b0);
         begin
            tick(10);
            start[0] = 1'b1;
            tick(1);
            start[0] = 1'b0;
         end
      join
      wait_done(0, 100);
      chk("busy_start_clr_count", clr_n[0], 1);
      chk("busy_start_val_count", val_n[0], 2);
      tick(5);
      chk("busy_start_no_restart", busy[0], 0);
      // abort after 10 samples of term 0
      reset_counts();
      pulse_start(0);
      for (int i = 0; i < 10; i++) feed(0, LANE_W'(300 + i), 1'b0);
      Clear = 1'b0;
      #1;
      chk("abort_acc_vec_nonzero", acc_vec[0] != '0, 0);
      chk("abort_state_idle", int'(dut_a.state), int'(IDLE));
      chk("abort_busy", busy[0], 0);
      chk("abort_s_ready", s_ready[0], 0);
      tick(2);
      @(negedge Clock);
      Clear = 1'b1;
      tick(5);
      chk("abort_no_done", done_n[0], 0);
      chk("abort_no_beat", val_n[0], 0);
      reset_counts();
      push_seq(0, 0, 400);
      push_seq(0, 1, 432);
      pulse_start(0);
      for (int i = 400; i < 464; i++) feed(0, LANE_W'(i), 1'b0);
      wait_done(0, 100);
      chk("restart_val_count", val_n[0], 2);
      chk("restart_queue_left", q[0].size(), 0);
      // full default pass with random samples
      reset_counts();
      exp_sum = 0;
      act_sum[1] = 0;
      pulse_start(1);
      for (int t = 0; t < NUM_TERMS; t++) begin
         for (int i = 0; i < LANES; i++) begin
            lv[i] = LANE_W'($urandom);
            b.vec[i*LANE_W +: LANE_W] = lv[i];
            exp_sum += longint'(lv[i]) * longint'($signed(wmem[1][t]));
         end
         b.w = wmem[1][t];
         b.term = t;
         q[1].push_back(b);
         for (int i = 0; i < LANES; i++) feed(1, lv[i], 1'b0);
      end
      wait_done(1, 100);
      chk("full_val_count", val_n[1], NUM_TERMS);
      chk("full_clr_count", clr_n[1], 1);
      chk("full_acc_sum", act_sum[1], exp_sum);
      chk("full_queue_left", q[1].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
